// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single ready-handshaked memory.
// One transaction at a time: IDLE grants, REQ strobes memory, RELEASE waits for R low, ACK pulses.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        err,
    output logic        read,
    output logic        write,
    output logic [15:0] MAR,
    output logic [15:0] MDR_in,
    input  logic [15:0] MDR,
    input  logic        R
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic            read_reg, read_next;
    logic            write_reg, write_next;
    logic [15:0]     mar_reg, mar_next;
    logic [15:0]     mdr_in_reg, mdr_in_next;
    logic            gnt_data_reg;
    logic            we_reg;
    logic            last_data_reg;
    logic            err_flag_reg;
    logic [CW-1:0]   cnt_reg;

    logic            grant_any;
    logic            grant_data;
    logic            timeout_hit;

    // Tie goes to whichever port was not served last.
    assign grant_any   = (state_reg == ST_IDLE) && (f_req || d_req);
    assign grant_data  = d_req && (!f_req || !last_data_reg);
    assign timeout_hit = (state_reg == ST_REQ) && !R && (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (f_req || d_req) state_next = ST_REQ;
            ST_REQ: begin
                if (R)                state_next = ST_RELEASE;
                else if (timeout_hit) state_next = ST_ACK;
            end
            ST_RELEASE: if (!R) state_next = ST_ACK;
            ST_ACK:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        read_next   = read_reg;
        write_next  = write_reg;
        mar_next    = mar_reg;
        mdr_in_next = mdr_in_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    mar_next    = grant_data ? d_addr : f_addr;
                    read_next   = !(grant_data && d_we);
                    write_next  = grant_data && d_we;
                    mdr_in_next = (grant_data && d_we) ? d_wdata : 16'h0000;
                end
            end
            ST_REQ: begin
                if (R || timeout_hit) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                end
            end
            default: begin
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
        f_ack = (state_reg == ST_ACK) && !gnt_data_reg;
        d_ack = (state_reg == ST_ACK) && gnt_data_reg;
        err   = (state_reg == ST_ACK) && err_flag_reg;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_reg      <= 1'b0;
            write_reg     <= 1'b0;
            mar_reg       <= '0;
            mdr_in_reg    <= '0;
            gnt_data_reg  <= 1'b0;
            we_reg        <= 1'b0;
            last_data_reg <= 1'b1;
            err_flag_reg  <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            read_reg   <= read_next;
            write_reg  <= write_next;
            mar_reg    <= mar_next;
            mdr_in_reg <= mdr_in_next;
            if (grant_any) begin
                gnt_data_reg  <= grant_data;
                we_reg        <= grant_data && d_we;
                last_data_reg <= grant_data;
                cnt_reg       <= '0;
            end else if (state_reg == ST_REQ && !R) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (timeout_hit) begin
                err_flag_reg <= 1'b1;
            end else if (state_reg == ST_ACK) begin
                err_flag_reg <= 1'b0;
            end
        end
    end

    // Per-port read-data holding registers; index 0 is fetch, 1 is data.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic        sel;
        logic [15:0] rdata_reg;

        assign sel = (gi == 1) ? gnt_data_reg : !gnt_data_reg;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rdata_reg <= '0;
            end else if (state_reg == ST_REQ && sel && !we_reg) begin
                if (R) begin
                    rdata_reg <= MDR;
                end else if (timeout_hit) begin
                    rdata_reg <= '0;
                end
            end
        end
    end

    assign f_rdata = g_port[0].rdata_reg;
    assign d_rdata = g_port[1].rdata_reg;
    assign read    = read_reg;
    assign write   = write_reg;
    assign MAR     = mar_reg;
    assign MDR_in  = mdr_in_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, tie alternation, write, fetch, long R, timeout, reset mid-REQ.
// Inputs driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        err;
    logic        read;
    logic        write;
    logic [15:0] MAR;
    logic [15:0] MDR_in;
    logic [15:0] MDR;
    logic        R;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_ack   (f_ack),
        .f_rdata (f_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .err     (err),
        .read    (read),
        .write   (write),
        .MAR     (MAR),
        .MDR_in  (MDR_in),
        .MDR     (MDR),
        .R       (R)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Both requests held; the acked requester drops for one IDLE cycle and re-raises.
    task automatic tie_txn(input bit exp_data, input logic [15:0] val);
        step();
        chk("tie_read", read, 1);
        chk("tie_mar", MAR, exp_data ? 16'h2000 : 16'h1000);
        R = 1'b1;
        MDR = val;
        step();
        R = 1'b0;
        MDR = 16'h0000;
        step();
        chk("tie_f_ack", f_ack, !exp_data);
        chk("tie_d_ack", d_ack, exp_data);
        chk("tie_rdata", exp_data ? d_rdata : f_rdata, val);
        if (exp_data) d_req = 1'b0;
        else          f_req = 1'b0;
        step();
        if (exp_data) d_req = 1'b1;
        else          f_req = 1'b1;
        $display("txn tie: served %s rdata %h", exp_data ? "data" : "fetch", val);
    endtask

    initial begin
        reset_n = 1'b0;
        f_req = 1'b0; f_addr = 16'h0000;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        MDR = 16'h0000; R = 1'b0;

        // Reset state
        step(); step();
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_mar", MAR, 0);
        chk("rst_mdr_in", MDR_in, 0);
        chk("rst_acks_err", {f_ack, d_ack, err}, 0);
        chk("rst_rdata", {f_rdata, d_rdata}, 0);
        $display("txn reset: outputs idle");

        // Tie right after reset: fetch first, then alternate
        reset_n = 1'b1;
        f_addr = 16'h1000; d_addr = 16'h2000; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        tie_txn(1'b0, 16'hA001);
        tie_txn(1'b1, 16'hA002);
        tie_txn(1'b0, 16'hA003);
        tie_txn(1'b1, 16'hA004);
        f_req = 1'b0; d_req = 1'b0;

        // Data write; address/data changes after grant must not leak through
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h3101; d_wdata = 16'h0007;
        step();
        chk("wr_write", write, 1);
        chk("wr_read", read, 0);
        chk("wr_mar", MAR, 16'h3101);
        chk("wr_mdr_in", MDR_in, 16'h0007);
        d_addr = 16'hFFFF; d_wdata = 16'hFFFF;
        step();
        chk("wr_mar_held", MAR, 16'h3101);
        chk("wr_mdr_in_held", MDR_in, 16'h0007);
        R = 1'b1; MDR = 16'hBEEF;
        step();
        chk("wr_write_drop", write, 0);
        R = 1'b0;
        step();
        chk("wr_d_ack", d_ack, 1);
        chk("wr_d_rdata_kept", d_rdata, 16'hA004);
        chk("wr_err", err, 0);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("wr_ack_pulse", d_ack, 0);
        $display("txn data write: addr 3101 wdata 0007");

        // Fetch only
        f_req = 1'b1; f_addr = 16'h3000;
        step();
        chk("f_read", read, 1);
        chk("f_write", write, 0);
        chk("f_mar", MAR, 16'h3000);
        chk("f_mdr_in", MDR_in, 0);
        R = 1'b1; MDR = 16'h5260;
        step();
        R = 1'b0;
        chk("f_read_drop", read, 0);
        step();
        chk("f_ack", f_ack, 1);
        chk("f_rdata", f_rdata, 16'h5260);
        chk("f_err", err, 0);
        chk("f_d_ack", d_ack, 0);
        f_req = 1'b0;
        step();
        chk("f_ack_pulse", f_ack, 0);
        chk("f_no_reissue", read, 0);
        $display("txn fetch: addr 3000 rdata 5260");

        // Long R: three high cycles keep the FSM in RELEASE
        f_req = 1'b1; f_addr = 16'h5555;
        step();
        chk("lr_read", read, 1);
        chk("lr_mar", MAR, 16'h5555);
        R = 1'b1; MDR = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            MDR = 16'hDEAD;
            chk("lr_read_low", read, 0);
            chk("lr_no_ack", f_ack, 0);
        end
        R = 1'b0;
        step();
        chk("lr_ack", f_ack, 1);
        chk("lr_rdata", f_rdata, 16'h1234);
        f_req = 1'b0;
        step();
        chk("lr_ack_pulse", f_ack, 0);
        step();
        chk("lr_no_reissue", read, 0);
        $display("txn long R: addr 5555 rdata 1234");

        // Timeout: R never rises, abort after 4 REQ cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h4444;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_read_held", read, 1);
            chk("to_no_ack", d_ack, 0);
        end
        step();
        chk("to_read_drop", read, 0);
        chk("to_d_ack", d_ack, 1);
        chk("to_err", err, 1);
        chk("to_rdata_zero", d_rdata, 0);
        chk("to_f_ack", f_ack, 0);
        d_req = 1'b0;
        step();
        chk("to_ack_pulse", {d_ack, err}, 0);
        $display("txn timeout: addr 4444 err pulsed");

        // Reset asserted during REQ
        f_req = 1'b1; f_addr = 16'h6666;
        step();
        chk("rr_read", read, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rr_read_async", read, 0);
        chk("rr_mar_async", MAR, 0);
        chk("rr_rdata_async", f_rdata, 0);
        f_req = 1'b0;
        step();
        step();
        chk("rr_no_ack", {f_ack, d_ack}, 0);
        reset_n = 1'b1;
        step();
        chk("rr_idle_after", {read, f_ack}, 0);
        f_req = 1'b1; f_addr = 16'h7777;
        step();
        chk("rr_new_read", read, 1);
        chk("rr_new_mar", MAR, 16'h7777);
        R = 1'b1; MDR = 16'h89AB;
        step();
        R = 1'b0;
        step();
        chk("rr_new_ack", f_ack, 1);
        chk("rr_new_rdata", f_rdata, 16'h89AB);
        f_req = 1'b0;
        step();
        chk("rr_new_ack_pulse", f_ack, 0);
        $display("txn reset mid-REQ then fetch: addr 7777 rdata 89AB");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles waited for R in REQ state before aborting.
REQ-002 Port clock  input  1  single system clock; all state changes on posedge clock.
REQ-003 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port f_req  input  1  fetch port read request, level, held until f_ack.
REQ-005 Port f_addr  input  16  fetch address, stable while f_req high.
REQ-006 Port f_ack  output  1  one-cycle pulse: fetch transaction finished.
REQ-007 Port f_rdata  output  16  fetch read data, valid with f_ack and held until next fetch grant.
REQ-008 Port d_req  input  1  data port request, level, held until d_ack.
REQ-009 Port d_we  input  1  data port direction: 1 write, 0 read.
REQ-010 Port d_addr  input  16  data address; d_wdata input 16 write data; both stable while d_req high.
REQ-011 Port d_ack  output  1  one-cycle pulse: data transaction finished; d_rdata output 16 read data, valid with d_ack.
REQ-012 Port err  output  1  pulses with f_ack or d_ack when that transaction timed out.
REQ-013 Ports read, write  output  1 each  memory strobes; MAR output 16; MDR_in output 16 write data to memory.
REQ-014 Ports MDR  input  16  memory read data; R  input  1  memory ready, high-pulse of one or more cycles.

Function
REQ-015 FSM states SHALL be IDLE, REQ, RELEASE, ACK; encoding free.
REQ-016 IDLE: sample f_req/d_req; if any high, grant one, latch its address (and d_wdata/d_we for data) into internal registers, go REQ next cycle.
REQ-017 Both requests high in IDLE: grant the port not granted last (round robin); after reset last-granted = data, so fetch wins first tie.
REQ-018 Single request: grant it regardless of last-granted; last-granted updates on every grant.
REQ-019 REQ: MAR = latched address; read=1 for fetch or data read, write=1 for data write, never both; MDR_in = latched wdata on writes, 0 on reads.
REQ-020 REQ with R=1: capture MDR into granted port's rdata register (reads only; writes leave rdata unchanged), drop strobes, go RELEASE.
REQ-021 Timeout counter clears on entry to REQ, increments each REQ cycle with R=0; reaching TIMEOUT: drop strobes, set err flag, rdata := 16'h0000 for reads, go ACK directly.
REQ-022 RELEASE: strobes low; stay while R=1; R=0 -> ACK.
REQ-023 ACK: pulse exactly one of f_ack/d_ack for one cycle (err with it if flagged), then IDLE; err flag clears on exit.
REQ-024 Minimum transaction latency: grant edge to ack = 3 cycles with R high one cycle and low the next.
REQ-025 Requests changing outside IDLE SHALL be ignored; address/data changes after grant SHALL not affect MAR/MDR_in.
REQ-026 Requester dropping req on the edge it sees ack SHALL not cause a second transaction; req still high in the following IDLE cycle is a new request.
REQ-027 read, write, MAR, MDR_in SHALL be registered outputs (no combinational path from f_*/d_* inputs).

Reset
REQ-028 reset_n=0 SHALL immediately force: state IDLE, read=0, write=0, MAR=0, MDR_in=0, f_ack=0, d_ack=0, err=0, f_rdata=0, d_rdata=0, timeout count 0, last-granted=data.
REQ-029 Reset mid-transaction SHALL abort it with no ack; operation resumes first IDLE cycle after reset_n rises.

Verification
REQ-030 Fetch only: f_req=1, f_addr=16'h3000, memory returns 16'h5260 -> read=1 with MAR=16'h3000, f_ack pulse with f_rdata=16'h5260, err=0, write never 1.
REQ-031 Data write: d_we=1, d_addr=16'h3101, d_wdata=16'h0007 -> write=1, MAR=16'h3101, MDR_in=16'h0007, d_ack pulse, d_rdata unchanged.
REQ-032 Tie: f_req and d_req high together after reset -> fetch served first, then data; repeated ties alternate F,D,F,D across 4 transactions.
REQ-033 Timeout: TIMEOUT=4, R held 0 -> strobes drop after 4 REQ cycles, d_ack and err pulse together, d_rdata=16'h0000.
REQ-034 Long R: R high 3 cycles -> FSM stays RELEASE until R low, exactly one ack, no reissued read.
REQ-035 Reset asserted during REQ -> read/write fall asynchronously, no ack; new f_req after release completes normally.
